jpeg_bitbuf: RTL

//  Bit-window buffer feeding the decoder control path. It packs incoming JPEG bytes MSB-first

---
 rtl/jpeg_bitbuf.sv | 91 +++++++++
 1 files changed

// File: rtl/jpeg_bitbuf.sv
// Bit-window buffer: packs JPEG bytes MSB-first into a shift buffer, exposes the next
// WIN_W stream bits, consumes pc_delta bits per cycle and strips 0xFF00 byte stuffing.
module jpeg_bitbuf #(
  parameter int WIN_W = 64,
  parameter int BUF_W = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             eof_in,
  input  logic             stuff_en,
  input  logic [7:0]       pc_delta,
  output logic [WIN_W-1:0] bit_window,
  output logic             bit_avali,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             err_over
);
  // Arithmetic width wide enough for both fill_cnt and pc_delta.
  localparam int DW = (CNT_W > 8) ? CNT_W : 8;
  localparam logic [DW-1:0] WIN_C = DW'(WIN_W);
  localparam logic [DW-1:0] RDY_C = DW'(BUF_W - 8);

  logic [BUF_W-1:0] buf_reg, buf_next, byte_pos;
  logic [CNT_W-1:0] fill_reg;
  logic [DW-1:0]    fill_ext, delta_ext, cons, base, fill_next;
  logic             last_ff_reg, last_ff_next;
  logic             eof_reg, eof_next;
  logic             err_reg, err_next;
  logic             accept, drop, append;

  assign fill_ext   = DW'(fill_reg);
  assign delta_ext  = DW'(pc_delta);
  assign bit_window = buf_reg[BUF_W-1 -: WIN_W];
  assign fill_cnt   = fill_reg;
  assign err_over   = err_reg;
  assign bit_avali  = (fill_ext >= WIN_C) | (eof_reg & (fill_ext != '0));
  assign byte_ready = (fill_ext <= RDY_C) & ~eof_reg;

  always_comb begin
    cons         = '0;
    err_next     = err_reg;
    last_ff_next = last_ff_reg;
    eof_next     = eof_reg;
    if (bit_avali) begin
      cons = (delta_ext < fill_ext) ? delta_ext : fill_ext;
      if ((delta_ext > WIN_C) || (delta_ext > fill_ext))
        err_next = 1'b1;
    end
    accept = byte_valid & byte_ready;
    // A 0x00 directly after 0xFF in entropy-coded data is a stuffing byte.
    drop   = accept & stuff_en & last_ff_reg & (byte_in == 8'h00);
    append = accept & ~drop;
    if (drop)
      last_ff_next = 1'b0;
    else if (append)
      last_ff_next = (byte_in == 8'hFF);
    if (accept && eof_in)
      eof_next = 1'b1;
    // New byte lands right after the bits that survive this cycle's consume.
    base      = fill_ext - cons;
    byte_pos  = {byte_in, {(BUF_W-8){1'b0}}} >> base;
    buf_next  = (buf_reg << cons) | (append ? byte_pos : '0);
    fill_next = base + (append ? DW'(8) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg     <= '0;
      fill_reg    <= '0;
      last_ff_reg <= 1'b0;
      eof_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else if (flush) begin
      buf_reg     <= '0;
      fill_reg    <= '0;
      last_ff_reg <= 1'b0;
      eof_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      buf_reg     <= buf_next;
      fill_reg    <= fill_next[CNT_W-1:0];
      last_ff_reg <= last_ff_next;
      eof_reg     <= eof_next;
      err_reg     <= err_next;
    end
  end
endmodule
